// File: rtl/fp_stream_capture.sv
// Sink for the FP FIR sample stream: show-ahead FIFO with overflow accounting and
// NaN/Inf/peak-magnitude monitoring. The input stream has no backpressure.
module fp_stream_capture #(
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              valid_in,
   input  logic [31:0]       data_in,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [31:0]       rd_data,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic [15:0]       drop_cnt,
   output logic              nan_seen,
   output logic              inf_seen,
   output logic [30:0]       peak_mag
);

   localparam logic [ADDR_W:0] FullCnt = (ADDR_W + 1)'(DEPTH);

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_W:0]   count_q;
   logic              overflow_q, nan_seen_q, inf_seen_q;
   logic [15:0]       drop_cnt_q;
   logic [30:0]       peak_mag_q;

   logic full, rd_fire, wr_acc, drop, mon, exp_ones, mant_zero, is_nan, is_inf;

   always_comb begin
      full      = (count_q == FullCnt);
      rd_fire   = (count_q != '0) && rd_ready && !clear;
      // A read in the same cycle frees the slot, so a full FIFO can still accept.
      wr_acc    = valid_in && !clear && (!full || rd_fire);
      drop      = valid_in && !clear && full && !rd_fire;
      mon       = valid_in && !clear;
      exp_ones  = &data_in[30:23];
      mant_zero = (data_in[22:0] == '0);
      is_nan    = exp_ones && !mant_zero;
      is_inf    = exp_ones && mant_zero;
   end

   // Storage carries no reset; contents are don't-care while empty.
   always_ff @(posedge clk) begin
      if (wr_acc && !rst) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
         nan_seen_q <= 1'b0;
         inf_seen_q <= 1'b0;
         peak_mag_q <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (rd_fire) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({wr_acc, rd_fire})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
               drop_cnt_q <= drop_cnt_q + 16'd1;
            end
         end
         if (mon && is_nan) begin
            nan_seen_q <= 1'b1;
         end
         if (mon && is_inf) begin
            inf_seen_q <= 1'b1;
         end
         if (mon && !is_nan && (data_in[30:0] > peak_mag_q)) begin
            peak_mag_q <= data_in[30:0];
         end
      end
   end

   assign rd_valid = (count_q != '0);
   assign rd_data  = mem[rd_ptr_q];
   assign count    = count_q;
   assign overflow = overflow_q;
   assign drop_cnt = drop_cnt_q;
   assign nan_seen = nan_seen_q;
   assign inf_seen = inf_seen_q;
   assign peak_mag = peak_mag_q;

endmodule

// File: tb/tb_fp_stream_capture.sv
// Directed bench for fp_stream_capture: ordering, latency, overflow, wrap, monitors,
// drop-counter saturation and reset mid-stream.
module tb_fp_stream_capture;

   localparam int unsigned DEPTH  = 32;
   localparam int unsigned ADDR_W = 5;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            clear = 1'b0;
   logic            valid_in = 1'b0;
   logic [31:0]     data_in = '0;
   logic            rd_ready = 1'b0;
   logic            rd_valid;
   logic [31:0]     rd_data;
   logic [ADDR_W:0] count;
   logic            overflow;
   logic [15:0]     drop_cnt;
   logic            nan_seen;
   logic            inf_seen;
   logic [30:0]     peak_mag;

   int checks = 0;
   int errors = 0;

   fp_stream_capture #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .valid_in (valid_in),
      .data_in  (data_in),
      .rd_ready (rd_ready),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .count    (count),
      .overflow (overflow),
      .drop_cnt (drop_cnt),
      .nan_seen (nan_seen),
      .inf_seen (inf_seen),
      .peak_mag (peak_mag)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (count !== 6'd0 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_fifo: count=%0d rd_valid=%b, required 0/0", count, rd_valid);
      end
      checks++;
      if (overflow !== 1'b0 || drop_cnt !== 16'd0 || nan_seen !== 1'b0 ||
          inf_seen !== 1'b0 || peak_mag !== 31'd0) begin
         errors++;
         $display("FAIL reset_status: ovf=%b drop=%0d nan=%b inf=%b peak=%h, required all 0",
                  overflow, drop_cnt, nan_seen, inf_seen, peak_mag);
      end
   endtask

   task automatic test_order();
      logic [31:0] vals [3];
      vals[0] = 32'h3F80_0000;
      vals[1] = 32'hC000_0000;
      vals[2] = 32'h3E80_0000;
      for (int i = 0; i < 3; i++) begin
         valid_in = 1'b1;
         data_in  = vals[i];
         step();
      end
      valid_in = 1'b0;
      checks++;
      if (count !== 6'd3 || rd_valid !== 1'b1 || rd_data !== 32'h3F80_0000) begin
         errors++;
         $display("FAIL order_fill: count=%0d rd_valid=%b rd_data=%h, required 3/1/3f800000",
                  count, rd_valid, rd_data);
      end
      checks++;
      if (peak_mag !== 31'h4000_0000) begin
         errors++;
         $display("FAIL order_peak: peak=%h, required 40000000", peak_mag);
      end
      rd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== vals[i]) begin
            errors++;
            $display("FAIL order_read%0d: rd_valid=%b rd_data=%h, required 1/%h",
                     i, rd_valid, rd_data, vals[i]);
         end
         step();
      end
      rd_ready = 1'b0;
      checks++;
      if (rd_valid !== 1'b0 || count !== 6'd0) begin
         errors++;
         $display("FAIL order_empty: rd_valid=%b count=%0d, required 0/0", rd_valid, count);
      end
   endtask

   task automatic test_latency();
      valid_in = 1'b1;
      data_in  = 32'hA5A5_5A5A;
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_before: rd_valid=%b, required 0", rd_valid);
      end
      step();
      valid_in = 1'b0;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 32'hA5A5_5A5A) begin
         errors++;
         $display("FAIL latency_after: rd_valid=%b rd_data=%h, required 1/a5a55a5a",
                  rd_valid, rd_data);
      end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      checks++;
      if (count !== 6'd0) begin
         errors++;
         $display("FAIL latency_drain: count=%0d, required 0", count);
      end
   endtask

   task automatic test_overflow();
      pulse_clear();
      for (int i = 0; i < DEPTH + 5; i++) begin
         valid_in = 1'b1;
         data_in  = 32'h1000_0000 + 32'(i);
         step();
      end
      valid_in = 1'b0;
      checks++;
      if (count !== 6'd32 || overflow !== 1'b1 || drop_cnt !== 16'd5) begin
         errors++;
         $display("FAIL overflow_state: count=%0d ovf=%b drop=%0d, required 32/1/5",
                  count, overflow, drop_cnt);
      end
      rd_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== 32'h1000_0000 + 32'(i)) begin
            errors++;
            $display("FAIL overflow_read%0d: rd_valid=%b rd_data=%h, required 1/%h",
                     i, rd_valid, rd_data, 32'h1000_0000 + 32'(i));
         end
         step();
      end
      rd_ready = 1'b0;
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL overflow_empty: rd_valid=%b, required 0", rd_valid);
      end
   endtask

   task automatic test_full_rw();
      pulse_clear();
      for (int i = 0; i < DEPTH; i++) begin
         valid_in = 1'b1;
         data_in  = 32'h2000_0000 + 32'(i);
         step();
      end
      rd_ready = 1'b1;
      for (int j = 0; j < 10; j++) begin
         data_in = 32'h2000_0000 + 32'(DEPTH + j);
         checks++;
         if (rd_data !== 32'h2000_0000 + 32'(j)) begin
            errors++;
            $display("FAIL fullrw_read%0d: rd_data=%h, required %h",
                     j, rd_data, 32'h2000_0000 + 32'(j));
         end
         step();
      end
      valid_in = 1'b0;
      rd_ready = 1'b0;
      checks++;
      if (count !== 6'd32 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL fullrw_state: count=%0d drop=%0d ovf=%b, required 32/0/0",
                  count, drop_cnt, overflow);
      end
      rd_ready = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== 32'h2000_0000 + 32'(10 + k)) begin
            errors++;
            $display("FAIL fullrw_drain%0d: rd_valid=%b rd_data=%h, required 1/%h",
                     k, rd_valid, rd_data, 32'h2000_0000 + 32'(10 + k));
         end
         step();
      end
      rd_ready = 1'b0;
   endtask

   task automatic test_monitors();
      logic [31:0] vals [4];
      vals[0] = 32'h4049_0FDB;
      vals[1] = 32'hC120_0000;
      vals[2] = 32'h7FC0_0000;
      vals[3] = 32'hFF80_0000;
      pulse_clear();
      for (int i = 0; i < 4; i++) begin
         valid_in = 1'b1;
         data_in  = vals[i];
         step();
         if (i == 2) begin
            checks++;
            if (peak_mag !== 31'h4120_0000 || nan_seen !== 1'b1 || inf_seen !== 1'b0) begin
               errors++;
               $display("FAIL mon_nan: peak=%h nan=%b inf=%b, required 41200000/1/0",
                        peak_mag, nan_seen, inf_seen);
            end
         end
      end
      valid_in = 1'b0;
      checks++;
      if (nan_seen !== 1'b1 || inf_seen !== 1'b1 || peak_mag !== 31'h7F80_0000 ||
          count !== 6'd4) begin
         errors++;
         $display("FAIL mon_flags: nan=%b inf=%b peak=%h count=%0d, required 1/1/7f800000/4",
                  nan_seen, inf_seen, peak_mag, count);
      end
      // A sample coinciding with clear must be ignored entirely.
      clear    = 1'b1;
      valid_in = 1'b1;
      data_in  = 32'h7F7F_FFFF;
      step();
      clear    = 1'b0;
      valid_in = 1'b0;
      checks++;
      if (nan_seen !== 1'b0 || inf_seen !== 1'b0 || peak_mag !== 31'd0 || count !== 6'd0 ||
          rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL mon_clear: nan=%b inf=%b peak=%h count=%0d rd_valid=%b, required 0",
                  nan_seen, inf_seen, peak_mag, count, rd_valid);
      end
   endtask

   task automatic test_saturation();
      pulse_clear();
      valid_in = 1'b1;
      data_in  = 32'h3F80_0000;
      rd_ready = 1'b0;
      for (int i = 0; i < 70000; i++) begin
         step();
      end
      checks++;
      if (drop_cnt !== 16'hFFFF || overflow !== 1'b1 || count !== 6'd32) begin
         errors++;
         $display("FAIL sat_drop: drop=%h ovf=%b count=%0d, required ffff/1/32",
                  drop_cnt, overflow, count);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (drop_cnt !== 16'd0 || overflow !== 1'b0 || count !== 6'd0 || rd_valid !== 1'b0 ||
          peak_mag !== 31'd0) begin
         errors++;
         $display("FAIL sat_reset: drop=%h ovf=%b count=%0d rd_valid=%b peak=%h, required 0",
                  drop_cnt, overflow, count, rd_valid, peak_mag);
      end
      data_in = 32'h1234_5678;
      step();
      valid_in = 1'b0;
      checks++;
      if (count !== 6'd1 || rd_valid !== 1'b1 || rd_data !== 32'h1234_5678 ||
          drop_cnt !== 16'd0 || peak_mag !== 31'h1234_5678) begin
         errors++;
         $display("FAIL sat_after: count=%0d rd_valid=%b rd_data=%h drop=%h peak=%h, required 1/1/12345678/0/12345678",
                  count, rd_valid, rd_data, drop_cnt, peak_mag);
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_order();
      test_latency();
      test_overflow();
      test_full_rw();
      test_monitors();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_stream_capture.md
Name: fp_stream_capture

Overview:
- Sink side of the FP FIR sample stream. Consumes the filter's valid/data output, which has no backpressure.
- Buffers accepted samples in a show-ahead FIFO that a downstream reader drains over a ready/valid port.
- Monitors the stream for IEEE-754 single-precision NaN and Inf values, tracks peak magnitude, and counts samples dropped on overflow.
- Sits directly after highpass_fir_fp, in place of a bench or host collector.

Parameters:
- DEPTH, 32, FIFO entries; must be a power of two, minimum 2.
- ADDR_W, 5, log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous soft clear of FIFO, counters and flags.
- valid_in  input  1  sample strobe from the filter; no ready is returned.
- data_in  input  32  IEEE-754 single-precision sample.
- rd_ready  input  1  reader accepts the head entry.
- rd_valid  output  1  FIFO non-empty.
- rd_data  output  32  head-of-FIFO sample (show-ahead).
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; a sample was dropped.
- drop_cnt  output  16  number of dropped samples; saturates at 65535.
- nan_seen  output  1  sticky; a NaN arrived on valid_in.
- inf_seen  output  1  sticky; a +/-Inf arrived on valid_in.
- peak_mag  output  31  maximum of data_in[30:0] over non-NaN samples.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Pointers and count = 0; rd_valid = 0.
  - overflow = 0, drop_cnt = 0, nan_seen = 0, inf_seen = 0, peak_mag = 0.
  - rd_data contents are don't-care while rd_valid = 0.
- clear: same effect as rst. rst has priority over clear. A valid_in in the same cycle as clear is discarded: not stored, not monitored, not counted as a drop.
- Write accept: valid_in=1 and (count<DEPTH, or a read fires in the same cycle). The sample is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Read fire: rd_valid=1 and rd_ready=1. rd_ptr increments modulo DEPTH. rd_ready while empty has no effect.
- Show-ahead read: rd_data = mem[rd_ptr] whenever rd_valid=1.
- Write-to-read latency: a sample written at edge N appears on rd_valid/rd_data after edge N. Empty FIFO: 1 cycle.
- Occupancy update, registered:
  - Write only: count+1.
  - Read only: count-1.
  - Both: unchanged.
  - rd_valid = (count != 0).
- Full with valid_in and a read firing: both occur, count stays DEPTH, no drop.
- Full with valid_in and no read:
  - Sample discarded and FIFO unchanged.
  - overflow <= 1.
  - drop_cnt <= drop_cnt+1, saturating at 16'hFFFF.
- Wrap-around: pointers are ADDR_W bits and wrap freely. Full/empty are derived from count, never from pointer equality alone.
- Monitors act on every valid_in sample, accepted or dropped (clear cycle excepted):
  - NaN: exp==8'hFF and mant!=0 -> nan_seen <= 1.
  - Inf: exp==8'hFF and mant==0 -> inf_seen <= 1.
  - Peak: non-NaN with data_in[30:0] > peak_mag -> peak_mag <= data_in[30:0]. The comparison is unsigned on the bit pattern, which is magnitude-ordered for non-NaN values. The sign bit is ignored.
  - Denormals and -0.0 are treated as ordinary values; -0.0 yields magnitude 0.
- Sticky flags clear only on rst or clear.
- No arithmetic is performed on sample data. Stored values are bit-exact copies of data_in.

Test Plan:
- Reset, then write 3 samples 3F800000, C0000000, 3E800000 with rd_ready=0 -> count=3, rd_valid=1, rd_data=3F800000. Raise rd_ready -> values come out in order; rd_valid=0 after the third.
- Empty FIFO, single write at edge N -> rd_valid=0 before edge N, 1 after; rd_data equals the written word.
- Write DEPTH+5 samples with rd_ready=0 -> count=32, overflow=1, drop_cnt=5. Drain -> first 32 samples out in order, none of the dropped ones.
- Full FIFO with valid_in=1 and rd_ready=1 for 10 cycles -> count stays 32, drop_cnt unchanged, output order preserved across pointer wrap.
- Stream 40490FDB, C1200000, 7FC00000, FF800000 -> nan_seen=1, inf_seen=1, peak_mag=7F800000 (the Inf). The NaN does not update peak_mag. Assert clear -> all flags, peak and count return to 0.
- Hold valid_in full with rd_ready=0 for 70000 cycles -> drop_cnt saturates at FFFF. Pulse rst mid-stream -> all outputs reset on the next edge, and the next sample is accepted normally.
